// File: rtl/deskew_registers.sv
// -----------------------------------------------------------------------------
// deskew_registers
//
// Output-side deskew stage for an N-lane systolic array. Result rows leave
// the array staggered: lane y of a row arrives y cycles after lane 0. Lane y
// is delayed here by N-1-y enabled cycles, so each row comes out aligned on a
// single cycle and is tagged with out_valid. Emitted rows are counted, and
// done pulses on the beat that completes a tile of ROWS rows.
//
// Parameters:
//   DATA_WIDTH  width of one signed lane
//   N           number of lanes (>= 1)
//   ROWS        result rows per tile (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         global advance enable; every register holds while low
//   clear      synchronous tile abort: empties the valid pipe and the row
//              counter (data registers are not cleared)
//   in_valid   skewed-stream valid, aligned with lane 0 of din
//   din        skewed lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dout       aligned lanes, same packing
//   out_valid  dout holds one complete aligned row
//   row_cnt    rows emitted in the current tile
//   done       one-cycle pulse on the beat that emits row ROWS
//
// Build option:
//   DESKEW_ZERO_FILL_EN  when defined, dout is forced to zero whenever
//                        out_valid is low (lane N-1 included). Timing,
//                        out_valid, row_cnt and done are unaffected.
// -----------------------------------------------------------------------------
module deskew_registers #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int ROWS       = 16,
    localparam int CNT_W     = $clog2(ROWS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [N*DATA_WIDTH-1:0] din,
    output logic [N*DATA_WIDTH-1:0] dout,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        row_cnt,
    output logic                    done
);

    logic [N*DATA_WIDTH-1:0] dout_raw;

    // -------------------------------------------------------------------------
    // Per-lane delay chains. Lane y has N-1-y registers; the last lane has
    // none and is a straight wire, which keeps the triangle at N(N-1)/2 regs.
    // -------------------------------------------------------------------------
    for (genvar y = 0; y < N; y++) begin : g_lane
        localparam int DEPTH = N - 1 - y;

        if (DEPTH == 0) begin : g_pass
            assign dout_raw[y*DATA_WIDTH +: DATA_WIDTH] = din[y*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] dly_q [DEPTH];

            // Data is deliberately not affected by clear; only the valid
            // pipe decides whether the contents mean anything.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        dly_q[k] <= '0;
                    end
                end else if (en) begin
                    dly_q[0] <= din[y*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k < DEPTH; k++) begin
                        dly_q[k] <= dly_q[k-1];
                    end
                end
            end

            assign dout_raw[y*DATA_WIDTH +: DATA_WIDTH] = dly_q[DEPTH-1];
        end
    end

    // -------------------------------------------------------------------------
    // Valid pipe: N-1 stages so out_valid lines up with the moment lane N-1
    // of the same row is presented on din.
    // -------------------------------------------------------------------------
    if (N == 1) begin : g_vld_wire
        assign out_valid = in_valid;
    end else begin : g_vld_pipe
        logic [N-2:0] vld_q;
        logic [N-2:0] vld_d;

        always_comb begin
            vld_d = vld_q;
            if (clear) begin
                vld_d = '0;
            end else if (en) begin
                vld_d[0] = in_valid;
                for (int k = 1; k < N - 1; k++) begin
                    vld_d[k] = vld_q[k-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
        end

        assign out_valid = vld_q[N-2];
    end

    // -------------------------------------------------------------------------
    // Row counter. A beat is an enabled cycle presenting a valid row; a beat
    // coinciding with clear is discarded, so it neither counts nor fires done.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] row_cnt_q;
    logic [CNT_W-1:0] row_cnt_d;
    logic             beat;
    logic             last_row;

    assign beat     = en & out_valid;
    assign last_row = (row_cnt_q == CNT_W'(ROWS - 1));

    always_comb begin
        row_cnt_d = row_cnt_q;
        if (clear) begin
            row_cnt_d = '0;
        end else if (beat) begin
            row_cnt_d = last_row ? '0 : row_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q <= '0;
        end else begin
            row_cnt_q <= row_cnt_d;
        end
    end

    assign row_cnt = row_cnt_q;
    assign done    = beat & last_row & ~clear;

    // -------------------------------------------------------------------------
    // Output bus
    // -------------------------------------------------------------------------
`ifdef DESKEW_ZERO_FILL_EN
    // Blank the bus between rows so downstream accumulators never see
    // partial-row residue.
    assign dout = out_valid ? dout_raw : '0;
`else
    assign dout = dout_raw;
`endif

endmodule

// File: doc/deskew_registers.md
Name: deskew_registers

Overview:
- Output-side counterpart of the input skew stage for the N-lane systolic array.
- Results leave the array's bottom edge staggered: lane y of a given result row arrives y cycles after lane 0.
- This block delays lane y by N-1-y enabled cycles, so a full result row emerges aligned on one cycle, tagged with out_valid.
- It also counts emitted rows and pulses done when a tile of ROWS rows has drained.

Parameters:
- DATA_WIDTH, 16, width of one signed lane.
- N, 16, number of lanes (array width); must be >= 1.
- ROWS, 16, result rows per tile; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global advance enable; when 0, every register holds.
- clear  in  1  synchronous tile abort; clears valid pipe and row counter, not data.
- in_valid  in  1  skewed-stream valid, aligned with lane 0 of din.
- din  in  N*DATA_WIDTH  skewed lanes, signed; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- dout  out  N*DATA_WIDTH  aligned lanes, same packing.
- out_valid  out  1  dout holds one complete aligned row.
- row_cnt  out  $clog2(ROWS+1)  rows emitted in the current tile.
- done  out  1  one-cycle pulse on the beat that emits row ROWS.

Behaviour:
- Reset: rst_n low asynchronously zeroes all lane delay registers, the valid pipe, row_cnt and done. Therefore dout = 0 except lane N-1, which is combinational from din. out_valid = 0 for N>1.
- Lane delay:
  - Lane y has a chain of N-1-y en-gated registers.
  - Lane N-1 has zero registers: dout lane N-1 = din lane N-1, combinational.
  - Lane 0 has N-1 registers.
  - Registers load only when en=1. Total register count is N(N-1)/2.
- Valid pipe:
  - in_valid passes through an N-1 stage en-gated shift chain; out_valid is the last stage.
  - For N=1, out_valid = in_valid combinationally.
  - out_valid is therefore aligned with the moment lane N-1 of the same row is presented.
- Beat definition: a beat occurs when en=1 and out_valid=1.
- Row counter:
  - On each beat, row_cnt increments.
  - If row_cnt == ROWS-1 on a beat:
    - done=1 that same cycle (combinational from the beat).
    - row_cnt wraps to 0 on the next edge.
  - done is never asserted without a beat.
- en=0:
  - Data, valid pipe and row_cnt all freeze.
  - done=0 and the beat is not counted.
  - out_valid still reflects the frozen pipe.
- clear:
  - When clear=1 at an edge, the valid pipe becomes all 0 and row_cnt becomes 0, regardless of en.
  - Data registers follow the normal en rule.
  - When clear and a beat coincide, the beat is discarded (no count) and done=0.
- Arithmetic: none; data is passed bit-exact, sign preserved.
- Bubbles: in_valid gaps propagate unchanged as out_valid gaps; throughput is one row per enabled cycle.
- Reset mid-tile: all in-flight rows are lost; row_cnt restarts at 0.

Optional Feature:
- Macro: DESKEW_ZERO_FILL_EN.
- Defined: dout is forced to all-zero whenever out_valid=0, including lane N-1. This gives a clean bus for downstream accumulators and waveforms.
- Undefined: dout shows raw register contents and the raw lane N-1 input regardless of out_valid.
- Neither setting changes timing, out_valid, row_cnt or done.

Test Plan:
- N=4, DW=16, ROWS=2, en=1. Drive row {lane0..3 = 1,2,3,4} skewed: lane y value at cycle t0+y, in_valid=1 at t0 only -> at cycle t0+3, out_valid=1 and dout={1,2,3,4}; row_cnt 0->1; done=0.
- Two consecutive rows {1,2,3,4} and {-5,-6,-7,-8}, skewed, in_valid high for t0 and t0+1 -> out_valid at t0+3 and t0+4 with the exact signed values; done=1 at t0+4; row_cnt returns to 0.
- Same row as scenario 1 with en=0 for 2 cycles at t0+1 -> output delayed exactly 2 cycles (at t0+5); no extra or lost beats; data intact.
- clear asserted on cycle t0+2 while one row is in flight -> no out_valid afterwards; row_cnt=0; done never pulses.
- rst_n dropped asynchronously mid-clock while out_valid=1 -> out_valid, row_cnt and done go to 0 immediately; lanes 0..N-2 read 0.
- DESKEW_ZERO_FILL_EN defined: din lane3=0x7FFF with in_valid=0 -> dout=0. Undefined: dout lane3=0x7FFF.
